pattern_scan_ctrl: RTL and testbench

//  Controller that feeds a serial bit-pattern detector from a parallel word source.

---
 rtl/pattern_scan_ctrl_if.sv | 20 ++
 rtl/pattern_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Word stream into the scan controller and the serial bit stream out of it.
interface pattern_scan_ctrl_if #(
    parameter int WORD_W = 8
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              bit_out;
    logic              bit_valid;

    modport master (
        output word_valid, word_data,
        input  word_ready, bit_out, bit_valid
    );

    modport slave (
        input  word_valid, word_data,
        output word_ready, bit_out, bit_valid
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serialises words MSB first, detects a programmable 1..PAT_W bit pattern
// (overlapping), counts matches and halts intake once the threshold is hit.
module pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             enable,
    pattern_scan_ctrl_if.slave wif,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             irq,
    input  logic             irq_clr,
    output logic             busy
);
    localparam int BC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HALT} state_t;

    state_t             state, state_nx;
    logic [WORD_W-1:0]  sreg;
    logic [BC_W-1:0]    bidx;
    logic [PAT_W-1:0]   hist, hist_nx, mask;
    logic [LEN_W-1:0]   seen, seen_inc;
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   thr_q, cnt_inc;
    logic               in_bit, last_bit, match, thr_hit, ready_c, accept, cfg_load;

    assign in_bit   = (state == S_SHIFT);
    assign last_bit = in_bit && (bidx == BC_W'(WORD_W - 1));

    // Window = current bit (LSB) plus older history; pattern MSB is the oldest bit.
    assign hist_nx  = (hist << 1) | PAT_W'(sreg[WORD_W-1]);
    assign seen_inc = (seen == LEN_W'(PAT_W)) ? seen : seen + 1'b1;
    assign mask     = {PAT_W{1'b1}} >> (LEN_W'(PAT_W) - len_q);
    assign match    = in_bit && (seen_inc >= len_q) && (((hist_nx ^ pat_q) & mask) == '0);
    assign cnt_inc  = (&match_count) ? match_count : match_count + 1'b1;
    // A clear in the same cycle zeroes the count, so it cannot trip the threshold.
    assign thr_hit  = match && !irq_clr && (thr_q != '0) && (cnt_inc == thr_q);

    // Only take a new word in IDLE or on the final bit, never on an aborting bit.
    assign ready_c  = enable && ((state == S_IDLE) || (last_bit && !thr_hit));
    assign accept   = wif.word_valid && ready_c;
    assign cfg_load = (state == S_IDLE) && cfg_we;

    assign wif.word_ready = ready_c;
    assign wif.bit_out    = sreg[WORD_W-1];
    assign wif.bit_valid  = in_bit;
    assign busy           = (state != S_IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state: threshold abort beats word completion; irq_clr releases HALT.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_SHIFT;
            S_SHIFT: begin
                if (thr_hit)       state_nx = S_HALT;
                else if (last_bit) state_nx = accept ? S_SHIFT : S_IDLE;
            end
            S_HALT:  if (irq_clr) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Shifter: load on accept, shift per bit; shifting out the last bit leaves it zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg <= '0;
            bidx <= '0;
        end else if (accept) begin
            sreg <= wif.word_data;
            bidx <= '0;
        end else if (in_bit) begin
            sreg <= thr_hit ? '0 : (sreg << 1);
            bidx <= bidx + 1'b1;
        end
    end

    // Configuration, accepted only while idle; out-of-range lengths mean full width.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            len_q <= LEN_W'(PAT_W);
            thr_q <= '0;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= (cfg_len == '0 || cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
            thr_q <= cfg_thresh;
        end
    end

    // History, seen-count, match counter and irq; irq_clr dominates everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist        <= '0;
            seen        <= '0;
            match_count <= '0;
            match_pulse <= 1'b0;
            irq         <= 1'b0;
        end else begin
            match_pulse <= match && !irq_clr;
            if (irq_clr || cfg_load) begin
                hist        <= '0;
                seen        <= '0;
                match_count <= '0;
            end else if (in_bit) begin
                hist <= hist_nx;
                seen <= seen_inc;
                if (match) match_count <= cnt_inc;
            end
            if (irq_clr)      irq <= 1'b0;
            else if (thr_hit) irq <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a bit-stream reference model.
module tb_pattern_scan_ctrl;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       cfg_we, enable, irq_clr;
    logic [4:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic [7:0] cfg_thresh;
    logic       match_pulse, irq, busy;
    logic [7:0] match_count;

    pattern_scan_ctrl_if #(.WORD_W(8)) wif();

    pattern_scan_ctrl #(.WORD_W(8), .PAT_W(5), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .enable(enable), .wif(wif),
        .match_pulse(match_pulse), .match_count(match_count), .irq(irq),
        .irq_clr(irq_clr), .busy(busy)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    int acc = 0, nbits = 0, run = 0, maxrun = 0;
    logic [7:0] wq[$];   // words waiting to be offered
    bit         bitq[$]; // bits of the accepted word still to appear
    bit         hq[$];   // bits seen since last clear
    int         plog[$]; // bit index at which each pulse was observed

    // model state
    logic [4:0] m_pat;
    int         m_len, m_thr, m_cnt;
    bit         m_irq, m_halt, m_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_match();
        if (hq.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (hq[hq.size() - 1 - k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        bitq.delete(); hq.delete();
        m_pat = '0; m_len = 5; m_thr = 0; m_cnt = 0;
        m_irq = 0; m_halt = 0; m_pend = 0;
    endtask

    // Producer: offers words from wq, records accepted bits for the model.
    always @(posedge clock) begin
        if (reset_n && wif.word_valid && wif.word_ready) begin
            for (int i = 7; i >= 0; i--) bitq.push_back(wif.word_data[i]);
            void'(wq.pop_front());
            acc++;
        end
        #1;
        wif.word_valid = (wq.size() != 0);
        wif.word_data  = (wq.size() != 0) ? wq[0] : 8'h00;
    end

    // Monitor: bit index of pulses and longest run of bit_valid.
    always @(negedge clock) begin
        if (match_pulse) plog.push_back(nbits);
        if (wif.bit_valid) begin
            nbits++; run++;
            if (run > maxrun) maxrun = run;
        end else run = 0;
    end

    // Compare every cycle against the model, then advance the model by one bit/cycle.
    always @(negedge clock) begin
        bit b, mt, hit, idle, exp_rdy;
        if (!reset_n) begin
            chk("rst_outs", {wif.bit_out, wif.bit_valid, match_pulse, irq, busy, match_count}, 0);
            model_reset();
        end else begin
            chk("busy", busy, (bitq.size() != 0) || m_halt);
            chk("bit_valid", wif.bit_valid, bitq.size() != 0);
            chk("match_pulse", match_pulse, m_pend);
            chk("match_count", match_count, m_cnt);
            chk("irq", irq, m_irq);
            if (bitq.size() != 0) begin
                b = bitq.pop_front();
                chk("bit_out", wif.bit_out, b);
                hq.push_back(b);
                if (hq.size() > 16) void'(hq.pop_front());
                mt  = model_match();
                hit = 0;
                if (irq_clr) begin
                    hq.delete(); m_cnt = 0; m_irq = 0;
                end else if (mt) begin
                    m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                    if (m_thr != 0 && m_cnt == m_thr) begin
                        m_irq = 1; m_halt = 1; hit = 1; bitq.delete();
                    end
                end
                m_pend  = mt && !irq_clr;
                exp_rdy = enable && (bitq.size() == 0) && !hit;
            end else begin
                idle    = !m_halt;
                m_pend  = 0;
                exp_rdy = enable && idle;
                if (irq_clr) begin
                    hq.delete(); m_cnt = 0; m_irq = 0; m_halt = 0;
                end
                if (cfg_we && idle) begin
                    m_pat = cfg_pattern;
                    m_len = (cfg_len == 0 || cfg_len > 5) ? 5 : int'(cfg_len);
                    m_thr = cfg_thresh;
                    hq.delete(); m_cnt = 0;
                end
            end
            chk("word_ready", wif.word_ready, exp_rdy);
        end
    end

    task automatic cfg(input logic [4:0] p, input logic [2:0] l, input logic [7:0] t);
        @(posedge clock); #1;
        cfg_pattern = p; cfg_len = l; cfg_thresh = t; cfg_we = 1'b1;
        @(posedge clock); #1;
        cfg_we = 1'b0;
    endtask

    task automatic clr_log();
        nbits = 0; run = 0; maxrun = 0; plog.delete();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin @(negedge clock); n++; end while ((wq.size() != 0 || busy) && n < 2000);
        chk({nm, "_idle_in_time"}, n < 2000, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_accept(input string nm, input int a0);
        int n = 0;
        while (acc == a0 && n < 50) begin @(negedge clock); n++; end
        chk({nm, "_accept_in_time"}, acc != a0, 1);
    endtask

    initial begin
        int n, a0;
        model_reset();
        reset_n = 0; enable = 0; cfg_we = 0; irq_clr = 0;
        cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        wif.word_valid = 0; wif.word_data = '0;
        repeat (3) @(posedge clock);
        #1 chk("reset_state", {wif.word_ready, wif.bit_out, wif.bit_valid, match_pulse, irq, busy, match_count}, 0);
        @(posedge clock); #1 reset_n = 1; enable = 1;

        // 1: 10101 over AA, pulses after bits 5 and 7
        cfg(5'b10101, 3'd5, 8'd0); clr_log();
        wq.push_back(8'hAA);
        wait_idle("t1");
        chk("t1_npulse", plog.size(), 2);
        if (plog.size() == 2) begin chk("t1_p0", plog[0], 5); chk("t1_p1", plog[1], 7); end
        chk("t1_count", match_count, 2);

        // 2: threshold 2 halts mid-word, FF waits until irq_clr
        cfg(5'b10101, 3'd5, 8'd2); clr_log();
        wq.push_back(8'hAA); wq.push_back(8'hFF);
        n = 0;
        while (!irq && n < 200) begin @(negedge clock); n++; end
        chk("t2_irq_set", irq, 1);
        chk("t2_bv_drop", wif.bit_valid, 0);
        chk("t2_pulse_with_irq", match_pulse, 1);
        chk("t2_bits_before_halt", nbits, 7);
        repeat (5) @(negedge clock);
        chk("t2_halt_busy", busy, 1);
        chk("t2_ff_held", wq.size(), 1);
        chk("t2_halt_ready", wif.word_ready, 0);
        chk("t2_count", match_count, 2);
        @(posedge clock); #1 irq_clr = 1;
        @(posedge clock); #1 irq_clr = 0;
        chk("t2_irq_clr", irq, 0);
        chk("t2_cnt_clr", match_count, 0);
        chk("t2_back_idle", busy, 0);
        wait_idle("t2");
        chk("t2_ff_taken", wq.size(), 0);
        chk("t2_count_end", match_count, 0);

        // 3: three words back to back, 24 gapless bits
        cfg(5'b10101, 3'd5, 8'd0); clr_log(); a0 = acc;
        wq.push_back(8'h12); wq.push_back(8'h34); wq.push_back(8'h56);
        wait_idle("t3");
        chk("t3_run", maxrun, 24);
        chk("t3_accepts", acc - a0, 3);

        // 4: len 3 pattern 101, then a match across a word boundary
        cfg(5'b00101, 3'd3, 8'd0); clr_log();
        wq.push_back(8'h55);
        wait_idle("t4a");
        chk("t4a_npulse", plog.size(), 3);
        if (plog.size() == 3) begin
            chk("t4a_p0", plog[0], 4); chk("t4a_p1", plog[1], 6); chk("t4a_p2", plog[2], 8);
        end
        chk("t4a_count", match_count, 3);
        cfg(5'b00101, 3'd3, 8'd0); clr_log();
        wq.push_back(8'h05); wq.push_back(8'h40);
        wait_idle("t4b");
        chk("t4b_npulse", plog.size(), 2);
        if (plog.size() == 2) begin chk("t4b_p0", plog[0], 8); chk("t4b_p1", plog[1], 10); end
        chk("t4b_count", match_count, 2);

        // 5: cfg_we while shifting is ignored; 304 matches saturate at 255
        cfg(5'b00001, 3'd1, 8'd0); clr_log(); a0 = acc;
        for (int i = 0; i < 38; i++) wq.push_back(8'hFF);
        wait_accept("t5", a0);
        repeat (2) @(posedge clock);
        #1 cfg_pattern = 5'b0; cfg_len = 3'd1; cfg_thresh = 8'd1; cfg_we = 1'b1;
        @(posedge clock); #1 cfg_we = 1'b0;
        wait_idle("t5");
        chk("t5_npulse", plog.size(), 304);
        chk("t5_count_sat", match_count, 255);
        chk("t5_irq", irq, 0);

        // 6: reset during 4th bit, then defaults (pattern 0, len 5) apply
        clr_log(); a0 = acc;
        wq.push_back(8'hFF);
        wait_accept("t6", a0);
        repeat (3) @(posedge clock);
        #2 reset_n = 0; enable = 0;
        #1 chk("t6_rst_outs", {wif.word_ready, wif.bit_out, wif.bit_valid, match_pulse, irq, busy, match_count}, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1; enable = 1;
        chk("t6_idle", busy, 0);
        clr_log();
        wq.push_back(8'h00);
        wait_idle("t6");
        chk("t6_npulse", plog.size(), 4);
        if (plog.size() == 4) begin chk("t6_p0", plog[0], 5); chk("t6_p3", plog[3], 8); end
        chk("t6_count", match_count, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
